// File: rtl/matriz_carregador.sv
// matriz_carregador: serial loader for the element-wise matrix ALU stage.
// Collects n*n elements for matrix A, then n*n for matrix B, and packs them
// row-major into 5x5 zero-padded buses. Element (r,c) sits at
// bits [(r*DIM_MAX+c)*ELEM_W +: ELEM_W]. The pair is held until the consumer
// accepts it.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, tamanho        request a new pair of size n (legal 2..DIM_MAX)
//   elem_in, elem_valid   element stream in (accepted when elem_ready)
//   elem_ready            high while loading A or B
//   matrizA, matrizB      packed matrices
//   mat_valid, mat_ready  output handshake
//   ocupado               high whenever not idle
//   erro                  one-cycle pulse after a start with illegal tamanho
module matriz_carregador #(
  parameter int unsigned ELEM_W  = 8,
  parameter int unsigned DIM_MAX = 5
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic [2:0]                        tamanho,
  input  logic [ELEM_W-1:0]                 elem_in,
  input  logic                              elem_valid,
  output logic                              elem_ready,
  output logic [DIM_MAX*DIM_MAX*ELEM_W-1:0] matrizA,
  output logic [DIM_MAX*DIM_MAX*ELEM_W-1:0] matrizB,
  output logic                              mat_valid,
  input  logic                              mat_ready,
  output logic                              ocupado,
  output logic                              erro
);

  localparam int unsigned MatW = DIM_MAX * DIM_MAX * ELEM_W;

  typedef enum logic [1:0] {StIdle, StLoadA, StLoadB, StDone} state_e;

  state_e          state_q, state_d;
  logic [2:0]      n_q, n_d;
  logic [2:0]      row_q, row_d;
  logic [2:0]      col_q, col_d;
  logic [MatW-1:0] mat_a_q, mat_a_d;
  logic [MatW-1:0] mat_b_q, mat_b_d;
  logic            erro_q, erro_d;

  logic            legal;
  logic            accept;
  logic            last_col;
  logic            last_elem;
  int unsigned     slot;

  always_comb begin
    legal     = (tamanho >= 3'd2) && (32'(tamanho) <= DIM_MAX);
    accept    = elem_valid && elem_ready;
    last_col  = (col_q == n_q - 3'd1);
    last_elem = last_col && (row_q == n_q - 3'd1);
    slot      = 32'(row_q) * DIM_MAX + 32'(col_q);

    state_d = state_q;
    n_d     = n_q;
    row_d   = row_q;
    col_d   = col_q;
    mat_a_d = mat_a_q;
    mat_b_d = mat_b_q;
    erro_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (legal) begin
            n_d     = tamanho;
            row_d   = '0;
            col_d   = '0;
            // Clearing here gives the zero padding for slots outside n x n.
            mat_a_d = '0;
            mat_b_d = '0;
            state_d = StLoadA;
          end else begin
            erro_d = 1'b1;
          end
        end
      end
      StLoadA, StLoadB: begin
        if (accept) begin
          if (state_q == StLoadA) begin
            mat_a_d[slot*ELEM_W +: ELEM_W] = elem_in;
          end else begin
            mat_b_d[slot*ELEM_W +: ELEM_W] = elem_in;
          end
          if (last_elem) begin
            row_d   = '0;
            col_d   = '0;
            state_d = (state_q == StLoadA) ? StLoadB : StDone;
          end else if (last_col) begin
            col_d = '0;
            row_d = row_q + 3'd1;
          end else begin
            col_d = col_q + 3'd1;
          end
        end
      end
      StDone: begin
        if (mat_ready) begin
          state_d = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      n_q     <= '0;
      row_q   <= '0;
      col_q   <= '0;
      mat_a_q <= '0;
      mat_b_q <= '0;
      erro_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      row_q   <= row_d;
      col_q   <= col_d;
      mat_a_q <= mat_a_d;
      mat_b_q <= mat_b_d;
      erro_q  <= erro_d;
    end
  end

  assign elem_ready = (state_q == StLoadA) || (state_q == StLoadB);
  assign mat_valid  = (state_q == StDone);
  assign ocupado    = (state_q != StIdle);
  assign erro       = erro_q;
  assign matrizA    = mat_a_q;
  assign matrizB    = mat_b_q;

endmodule

// File: tb/tb_matriz_carregador.sv
// Bench for matriz_carregador: table of load scenarios checked against a
// row-major packing model, plus hand-written handshake, error and reset cases.
module tb_matriz_carregador;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [2:0]   tamanho;
  logic [7:0]   elem_in;
  logic         elem_valid;
  logic         elem_ready;
  logic [199:0] matrizA;
  logic [199:0] matrizB;
  logic         mat_valid;
  logic         mat_ready;
  logic         ocupado;
  logic         erro;

  matriz_carregador dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .tamanho    (tamanho),
    .elem_in    (elem_in),
    .elem_valid (elem_valid),
    .elem_ready (elem_ready),
    .matrizA    (matrizA),
    .matrizB    (matrizB),
    .mat_valid  (mat_valid),
    .mat_ready  (mat_ready),
    .ocupado    (ocupado),
    .erro       (erro)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]   vals[$];
  logic [199:0] exp_a;
  logic [199:0] exp_b;

  // a_base < 0 selects random element values; exp_lat < 0 means "not fixed".
  typedef struct {
    int n;
    int vmode;   // 0: valid held high, 1: toggling 1,0,..., 2: random
    int a_base;
    int b_base;
    int exp_lat;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference packing: stream is row-major over an n x n matrix, placed in a
  // 5x5 grid of bytes, everything else zero.
  function automatic logic [199:0] build(input int n, input int off);
    logic [199:0] m;
    m = '0;
    for (int r = 0; r < n; r++) begin
      for (int c = 0; c < n; c++) begin
        m[(r*5+c)*8 +: 8] = vals[off + r*n + c];
      end
    end
    return m;
  endfunction

  task automatic run_load(input int n, input int vmode, input int a_base, input int b_base,
                          input int exp_lat);
    int beats;
    int total;
    int lat;
    bit v;
    total = 2 * n * n;
    vals.delete();
    for (int i = 0; i < total; i++) begin
      if (a_base < 0) vals.push_back(8'($urandom));
      else if (i < n * n) vals.push_back(8'(a_base + i));
      else vals.push_back(8'(b_base + i - n * n));
    end
    start = 1'b1; tamanho = 3'(n); elem_valid = 1'b0; mat_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    beats = 0;
    lat = -1;
    for (int k = 1; k <= 4 * total + 40; k++) begin
      chk("mat_valid_during_load", {199'b0, mat_valid}, {199'b0, beats == total});
      chk("elem_ready_during_load", {199'b0, elem_ready}, {199'b0, beats != total});
      chk("ocupado_during_load", {199'b0, ocupado}, 200'd1);
      if (beats == total) begin
        lat = k;
        break;
      end
      case (vmode)
        0:       v = 1'b1;
        1:       v = (k % 2 == 1);
        default: v = (k > 3 * total) || ($urandom_range(0, 9) < 7);
      endcase
      elem_valid = v;
      elem_in = v ? vals[beats] : 8'($urandom);
      if (v) beats++;
      @(negedge clk);
    end
    elem_valid = 1'b0;
    if (lat < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL load_timeout: got no mat_valid, required mat_valid within budget (n=%0d)", n);
    end else if (exp_lat >= 0) begin
      chk("latency", 200'(lat), 200'(exp_lat));
    end
    exp_a = build(n, 0);
    exp_b = build(n, n * n);
    chk("matrizA_packed", matrizA, exp_a);
    chk("matrizB_packed", matrizB, exp_b);
    // A beat offered in DONE must not be taken.
    elem_valid = 1'b1; elem_in = 8'hEE;
    @(negedge clk);
    elem_valid = 1'b0;
    chk("matrizA_after_extra_beat", matrizA, exp_a);
    chk("matrizB_after_extra_beat", matrizB, exp_b);
    chk("mat_valid_held", {199'b0, mat_valid}, 200'd1);
  endtask

  task automatic hold_release();
    for (int i = 0; i < 10; i++) begin
      mat_ready = 1'b0;
      start = (i % 3 == 0);
      tamanho = 3'd2;
      @(negedge clk);
      chk("mat_valid_hold", {199'b0, mat_valid}, 200'd1);
      chk("matrizA_hold", matrizA, exp_a);
      chk("matrizB_hold", matrizB, exp_b);
    end
    chk("erro_hold", {199'b0, erro}, 200'd0);
    // start coincident with the handshake is ignored too.
    mat_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    mat_ready = 1'b0; start = 1'b0;
    chk("ocupado_after_accept", {199'b0, ocupado}, 200'd0);
    chk("mat_valid_after_accept", {199'b0, mat_valid}, 200'd0);
    chk("erro_after_accept", {199'b0, erro}, 200'd0);
    chk("matrizA_in_idle", matrizA, exp_a);
    chk("matrizB_in_idle", matrizB, exp_b);
    @(negedge clk);
    chk("ocupado_stays_idle", {199'b0, ocupado}, 200'd0);
    chk("elem_ready_idle", {199'b0, elem_ready}, 200'd0);
  endtask

  initial begin
    logic [2:0] bad[4];
    rst_n = 1'b0; start = 1'b0; tamanho = '0; elem_in = '0; elem_valid = 1'b0;
    mat_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_matrizA", matrizA, 200'd0);
    chk("reset_matrizB", matrizB, 200'd0);
    chk("reset_flags", {196'b0, elem_ready, mat_valid, ocupado, erro}, 200'd0);
    rst_n = 1'b1;
    @(negedge clk);

    tbl[0] = '{n: 5, vmode: 0, a_base: 1,  b_base: 101, exp_lat: 51};
    tbl[1] = '{n: 2, vmode: 0, a_base: 1,  b_base: 5,   exp_lat: 9};
    tbl[2] = '{n: 3, vmode: 1, a_base: 10, b_base: 40,  exp_lat: 36};
    tbl[3] = '{n: 4, vmode: 2, a_base: -1, b_base: -1,  exp_lat: -1};
    tbl[4] = '{n: 5, vmode: 2, a_base: -1, b_base: -1,  exp_lat: -1};
    for (int t = 0; t < 5; t++) begin
      run_load(tbl[t].n, tbl[t].vmode, tbl[t].a_base, tbl[t].b_base, tbl[t].exp_lat);
      hold_release();
    end

    // Illegal sizes: one-cycle erro, stay idle, outputs untouched.
    bad[0] = 3'd7; bad[1] = 3'd1; bad[2] = 3'd0; bad[3] = 3'd6;
    for (int i = 0; i < 4; i++) begin
      start = 1'b1; tamanho = bad[i];
      @(negedge clk);
      start = 1'b0;
      chk("erro_pulse", {199'b0, erro}, 200'd1);
      chk("ocupado_on_bad", {199'b0, ocupado}, 200'd0);
      chk("matrizA_on_bad", matrizA, exp_a);
      @(negedge clk);
      chk("erro_one_cycle", {199'b0, erro}, 200'd0);
      chk("ocupado_after_bad", {199'b0, ocupado}, 200'd0);
    end

    // Reset partway through a 5x5 load.
    start = 1'b1; tamanho = 3'd5;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      elem_valid = 1'b1; elem_in = 8'(200 + i);
      @(negedge clk);
    end
    elem_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("abort_matrizA", matrizA, 200'd0);
    chk("abort_matrizB", matrizB, 200'd0);
    chk("abort_flags", {196'b0, elem_ready, mat_valid, ocupado, erro}, 200'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_load(4, 2, -1, -1, -1);
    hold_release();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/matriz_carregador.md
Name: matriz_carregador

Overview:
- Upstream loader for the element-wise matrix ALU stage.
- Accepts a serial stream of signed/unsigned 8-bit elements over a valid/ready handshake.
- Assembles two packed 5x5 matrices (A, then B) of 200 bits each, with zero padding for smaller sizes.
- Presents both matrices to the ALU with a valid/ready output handshake, held stable until accepted.

Parameters:
- ELEM_W, 8, element width in bits.
- DIM_MAX, 5, maximum matrix dimension; matrix buses are DIM_MAX*DIM_MAX*ELEM_W bits wide.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin loading a matrix pair.
- tamanho  input  3  matrix dimension n, sampled on the accepted start; legal values 2..5.
- elem_in  input  8  incoming element.
- elem_valid  input  1  elem_in is valid this cycle.
- elem_ready  output  1  loader accepts elem_in this cycle.
- matrizA  output  200  packed matrix A; element (r,c) at bits [(r*5+c)*8 +: 8].
- matrizB  output  200  packed matrix B, same packing as matrizA.
- mat_valid  output  1  matrizA and matrizB are complete and stable.
- mat_ready  input  1  consumer accepts the pair.
- ocupado  output  1  high in every state except IDLE.
- erro  output  1  one-cycle pulse when start arrives with an illegal tamanho.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE.
  - matrizA, matrizB, row/column counters and latched n are cleared to 0.
  - elem_ready, mat_valid, ocupado and erro are 0.
- FSM states: IDLE, LOAD_A, LOAD_B, DONE.
- IDLE:
  - On start=1 with tamanho in 2..5: latch n, zero both matrix registers, clear row and column counters, go to LOAD_A next cycle.
  - On start=1 with tamanho in {0,1,6,7}: pulse erro for one cycle and stay in IDLE.
- LOAD_A and LOAD_B:
  - elem_ready=1 in both states.
  - An element is accepted only on a cycle with elem_valid && elem_ready.
  - Each accepted element is written to slot (r*5+c) of the current matrix.
  - The column counter increments after each accept. When it reaches n-1 it wraps to 0 and the row counter increments.
  - Accepting element (n-1,n-1) moves the FSM LOAD_A->LOAD_B or LOAD_B->DONE next cycle, and clears both counters.
  - Slots with r>=n or c>=n remain 0.
  - No element is lost or duplicated when elem_valid toggles between beats.
- DONE:
  - elem_ready=0 and mat_valid=1.
  - matrizA and matrizB are held constant.
  - On mat_valid && mat_ready, go to IDLE next cycle; mat_valid drops that next cycle.
  - Matrix outputs keep their values in IDLE until the next legal start.
- Latency:
  - First accepted element is the cycle after start at the earliest.
  - With elem_valid held high, mat_valid rises exactly 2*n*n+1 cycles after the start cycle.
- start outside IDLE is ignored and does not assert erro.
- A start in the same cycle as the DONE handshake is ignored, because the FSM is not in IDLE that cycle.
- ocupado = (state != IDLE).
- Element values are stored verbatim: no arithmetic, no sign extension.
- Reset asserted mid-load aborts immediately to the reset state. No partial matrix is ever presented with mat_valid=1.

Test Plan:
- Reset, then tamanho=5, start, stream 1..25 then 101..125 with elem_valid held high -> mat_valid rises at cycle 51 after start; matrizA[7:0]=1, matrizA[199:192]=25, matrizB[7:0]=101, matrizB[199:192]=125.
- tamanho=2, stream A=(1,2,3,4), B=(5,6,7,8) -> matrizA slots 0,1,5,6 hold 1,2,3,4; matrizB slots 0,1,5,6 hold 5,6,7,8; all other bytes 0; mat_valid rises 9 cycles after start.
- tamanho=3 with elem_valid toggling 1,0,1,0 -> exactly 18 elements captured in order; elem_ready=0 in DONE; an extra elem_valid beat in DONE is not captured.
- In DONE, hold mat_ready=0 for 10 cycles -> mat_valid and matrix outputs stay stable; pulse mat_ready=1 -> IDLE next cycle, ocupado=0; start during those held cycles has no effect.
- start with tamanho=7, then tamanho=1 -> erro pulses one cycle each; FSM stays in IDLE; ocupado=0; outputs unchanged.
- Deassert rst_n after 12 elements of a tamanho=5 load -> all outputs 0 immediately; after release, a fresh tamanho=4 load completes with correct packing and no leftover data from the aborted load.
